// File: rtl/sram_pkg.sv
// Shared definitions for the 1024x32 SRAM block and the masters that talk to it.
// The SRAM wrapper and its neighbours import this package.
package sram_pkg;

  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } sram_state_t;

endpackage

// File: rtl/sram_burst_addr_gen.sv
// Burst address / word-count tracker for the SRAM burst reader.
// Address wraps modulo 2**ADDR_W; remaining is wide enough to hold a full-memory burst.
module sram_burst_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              step,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [LEN_W-1:0]  remaining,
  output logic              last
);

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;

  always_comb begin
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    if (load) begin
      cur_addr_d  = base_addr;
      remaining_d = len;
    end else if (step) begin
      cur_addr_d  = cur_addr_q + ADDR_W'(1);
      remaining_d = remaining_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign cur_addr  = cur_addr_q;
  assign remaining = remaining_q;
  assign last      = (remaining_q == LEN_W'(1));

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read master for the 1024x32 SRAM: one read outstanding at a time,
// words streamed in address order on a valid/ready port with a last flag.
module sram_burst_reader
  import sram_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int LEN_W   = 11,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_read_en,
  input  logic [DATA_W-1:0] sram_read_data,
  input  logic [1:0]        sram_state
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    OUT  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              error_q, error_d;

  logic              ag_load, ag_step, ag_last;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  sram_state_t       sst;

  assign sst = sram_state_t'(sram_state);

  sram_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .base_addr (base_addr),
    .len       (burst_len),
    .step      (ag_step),
    .cur_addr  (cur_addr),
    .remaining (remaining),
    .last      (ag_last)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    data_d     = data_q;
    error_d    = error_q;
    ag_load    = 1'b0;
    ag_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          error_d    = 1'b0;
          wait_cnt_d = '0;
          if (burst_len != '0) begin
            ag_load = 1'b1;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        // First READ cycle may still show ACCESS left over from the previous word.
        if (wait_cnt_q != '0 && sst == ACCESS) begin
          data_d  = sram_read_data;
          state_d = OUT;
        end else if (wait_cnt_q != '0 && sst == ERROR) begin
          error_d = 1'b1;
          state_d = ERR;
        end else if (wait_cnt_d == WCNT_W'(TIMEOUT)) begin
          error_d = 1'b1;
          state_d = ERR;
        end
      end
      OUT: begin
        if (out_ready) begin
          ag_step = 1'b1;
          if (ag_last) begin
            state_d = DONE;
          end else begin
            wait_cnt_d = '0;
            state_d    = READ;
          end
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        error_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      data_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      data_q     <= data_d;
      error_q    <= error_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign error        = error_q;
  assign out_valid    = (state_q == OUT);
  assign out_last     = (state_q == OUT) && ag_last;
  assign out_data     = data_q;
  assign sram_read_en = (state_q == READ);
  assign sram_addr    = (state_q == READ) ? cur_addr : '0;

  // remaining is only consulted through ag_last
  logic unused_ok;
  assign unused_ok = ^remaining;

endmodule

// File: doc/sram_burst_reader.md
Name: sram_burst_reader

Overview:
- Upstream master for the 1024x32 SRAM block; fetches a contiguous burst of words and streams them to the systolic-array operand loader.
- Drives the SRAM request pins, obeys the SRAM state handshake, and presents each word on a valid/ready stream with a last flag.
- Read-only: SRAM write enable is owned by a separate writer and arbitrated at top level.

Parameters:
- ADDR_W, 10, SRAM word address width (1024 words).
- DATA_W, 32, SRAM word width.
- LEN_W, 11, burst length width; legal lengths are 0..1024.
- TIMEOUT, 64, maximum cycles spent in READ before an error is declared.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle burst request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, latched on accepted start.
- burst_len  in  LEN_W  number of words, latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at burst end, normal or error.
- error  out  1  sticky error flag; cleared on the next accepted start or on rst.
- out_data  out  DATA_W  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  high with the final word of the burst.
- sram_addr  out  ADDR_W  to SRAM address.
- sram_read_en  out  1  to SRAM read enable.
- sram_read_data  in  DATA_W  from SRAM.
- sram_state  in  2  from SRAM. Encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: busy, done, error, out_valid, out_last, out_data, sram_addr, sram_read_en.
  - Internal counters clear.
  - rst mid-burst abandons the burst with no done pulse.
- IDLE:
  - start with burst_len != 0: latch cur_addr = base_addr and remaining = burst_len, clear error, go to READ.
  - start with burst_len == 0: clear error, pulse done on the next cycle (via DONE), issue no SRAM access.
  - start is ignored while busy.
- READ:
  - sram_read_en = 1 and sram_addr = cur_addr, both held stable throughout READ.
  - wait_cnt increments every READ cycle.
  - sram_state is ignored on the first READ cycle so a stale ACCESS from the previous word cannot be taken.
  - From the second cycle onward:
    - ACCESS: capture sram_read_data into the output register and go to OUT.
    - ERROR: go to ERR.
    - FREE or BUSY: stay in READ.
  - wait_cnt reaching TIMEOUT: go to ERR.
  - Minimum SRAM-to-stream latency is 2 cycles from READ entry to out_valid.
- OUT:
  - sram_read_en = 0, out_valid = 1, out_last = (remaining == 1).
  - out_data is held stable until the handshake.
  - On out_valid && out_ready:
    - cur_addr = (cur_addr + 1) mod 1024; address 1023 wraps to 0 with no error.
    - remaining decrements.
    - If remaining was 1: go to DONE. Otherwise clear wait_cnt and go to READ.
  - No backpressure limit: OUT may hold indefinitely.
- DONE: done = 1 for exactly one cycle, then IDLE.
- ERR:
  - sram_read_en = 0, out_valid = 0, error set.
  - Next cycle goes to DONE, so done pulses with error high.
  - error stays high in IDLE until the next accepted start.
- Ordering: at most one outstanding SRAM read at any time; words are emitted strictly in address order.
- Arithmetic: remaining is LEN_W bits so 1024 is representable; the address adder is ADDR_W bits and wraps naturally.

Decomposition:
- Shared package sram_pkg:
  - sram_state_t enum: FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3.
  - Constants SRAM_ADDR_W = 10 and SRAM_DATA_W = 32.
  - The SRAM wrapper's neighbours import this package too.
- Reader FSM state enum (IDLE, READ, OUT, DONE, ERR) is local to the module.
- One small sub-module is natural: sram_burst_addr_gen, holding the cur_addr and remaining counters with load/step/last outputs.

Test Plan:
- Basic burst: SRAM preloaded with mem[i] = i * 3; start with base 5, len 4; SRAM gives ACCESS 2 cycles after request; out_ready = 1 -> words 15, 18, 21, 24 in order; out_last only on 24; one done pulse; error = 0.
- Wrap-around: base 1022, len 4 -> sram_addr sequence 1022, 1023, 0, 1; data matches memory; done pulses.
- Backpressure: len 3, out_ready low for 5 cycles on word 2 -> out_data stable, sram_read_en = 0 during the stall, no skipped or duplicated words.
- Zero length and stale state: start with len 0 -> done on the next cycle, sram_read_en never rises. Separately, hold sram_state = ACCESS on the first READ cycle -> word is not captured until a later ACCESS.
- Errors:
  - sram_state = ERROR mid-burst (word 2 of 4) -> no further out_valid, done pulses with error = 1, error stays high until the next start.
  - sram_state held BUSY for 64 cycles -> same timeout error.
- Reset mid-burst: assert rst during OUT -> next cycle all outputs 0, state IDLE, no done pulse; a following start runs normally.
